pri_scan_encoder: RTL and testbench

Parametrised, sequential successor to the team's 4-to-2 priority encoder with valid flag. It captures an N-bit request word and emits the index of every set bit, one index per accepted handshake, in priority order. Two priority modes are supported: fixed highest-index-first, and round-robin with a pointer that persists across bursts. It sits between request sources (interrupt lines, channel flags) and a downstream consumer that services one index at a time.

---
 rtl/pri_scan_encoder_if.sv | 34 +++
 rtl/pri_scan_encoder.sv | 125 ++++++++++++
 tb/tb_pri_scan_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pri_scan_encoder_if.sv
// pri_scan_encoder_if
//   Request/index handshake bundle for pri_scan_encoder.
//   master: request source + downstream consumer side (drives req_in, load, rdy_in)
//   slave : the encoder (drives idx_out, valid, busy, done)
//   req_in  [N-1:0] request word, sampled on an accepted load
//   load            capture strobe, honoured only while busy=0
//   rdy_in          consumer ready; index consumed when valid && rdy_in
//   idx_out [W-1:0] offered index
//   valid           idx_out meaningful
//   busy            captured word still has unconsumed bits
//   done            one-cycle pulse at burst end or on an empty load
interface pri_scan_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req_in;
  logic         load;
  logic         rdy_in;
  logic [W-1:0] idx_out;
  logic         valid;
  logic         busy;
  logic         done;

  modport master (
    output req_in, load, rdy_in,
    input  idx_out, valid, busy, done
  );

  modport slave (
    input  req_in, load, rdy_in,
    output idx_out, valid, busy, done
  );
endinterface

// File: rtl/pri_scan_encoder.sv
// pri_scan_encoder
//   Captures an N-bit request word and emits the index of every set bit,
//   one per accepted handshake, in priority order.
//   MODE 0: highest set index first.
//   MODE 1: round-robin, search descends from a pointer that persists
//           across bursts and wraps from 0 to N-1.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pri_scan_encoder_if.slave (req_in/load/rdy_in in, idx_out/valid/busy/done out)
module pri_scan_encoder #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input logic              clk,
  input logic              rst,
  pri_scan_encoder_if.slave bus
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] TOP = W'(N - 1);
  localparam logic [N-1:0] ONE = N'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pend_q,  pend_d;
  logic [W-1:0] idx_q,   idx_d;
  logic         valid_q, valid_d;
  logic         done_q,  done_d;
  logic [W-1:0] ptr_q,   ptr_d;

  logic [N-1:0] rem;
  logic [W-1:0] nptr;

  // Priority pick over vec. MODE 0 ignores start; MODE 1 walks downward
  // from start, wrapping, and takes the first set bit.
  function automatic logic [W-1:0] select_idx(input logic [N-1:0] vec,
                                               input logic [W-1:0] start);
    logic [W-1:0] sel;
    logic         found;
    int unsigned  j;
    sel   = '0;
    found = 1'b0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (vec[i[W-1:0]]) sel = W'(i);
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        j = (32'(start) + N - k) % N;
        if (!found && vec[j[W-1:0]]) begin
          sel   = W'(j);
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    rem     = pend_q & ~(ONE << idx_q);
    nptr    = ptr_q;
    if (MODE == 1) nptr = (idx_q == '0) ? TOP : idx_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (|bus.req_in) begin
            pend_d  = bus.req_in;
            idx_d   = select_idx(bus.req_in, ptr_q);
            valid_d = 1'b1;
            state_d = SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        if (valid_q && bus.rdy_in) begin
          // The next pick uses the pointer as it will be after this
          // consume, so round-robin order holds within a burst too.
          pend_d = rem;
          ptr_d  = nptr;
          if (|rem) begin
            idx_d = select_idx(rem, nptr);
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ptr_q   <= TOP;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.idx_out = idx_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = (state_q == SCAN);
  assign bus.done    = done_q;
endmodule

// File: tb/tb_pri_scan_encoder.sv
module tb_pri_scan_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pri_scan_encoder_if #(.N(8)) ifa ();
  pri_scan_encoder_if #(.N(8)) ifb ();
  pri_scan_encoder_if #(.N(4)) ifc ();

  pri_scan_encoder #(.N(8), .MODE(0)) u_m0 (.clk(clk), .rst(rst), .bus(ifa));
  pri_scan_encoder #(.N(8), .MODE(1)) u_m1 (.clk(clk), .rst(rst), .bus(ifb));
  pri_scan_encoder #(.N(4), .MODE(0)) u_n4 (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    int          dut;   // 0: N8 MODE0, 1: N8 MODE1, 2: N4 MODE0
    logic [7:0]  req;
    int          n;
    int          seq[4];
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic ld, input logic [7:0] req);
    case (d)
      0: begin ifa.load = ld; ifa.req_in = req; end
      1: begin ifb.load = ld; ifb.req_in = req; end
      default: begin ifc.load = ld; ifc.req_in = req[3:0]; end
    endcase
  endtask

  task automatic set_rdy(input logic r);
    ifa.rdy_in = r;
    ifb.rdy_in = r;
    ifc.rdy_in = r;
  endtask

  // exp_idx < 0 skips the index comparison
  task automatic expect_out(input int d, input string name, input int exp_idx,
                            input int ev, input int eb, input int ed);
    int idx, v, b, dn;
    case (d)
      0: begin idx = int'(ifa.idx_out); v = int'(ifa.valid); b = int'(ifa.busy); dn = int'(ifa.done); end
      1: begin idx = int'(ifb.idx_out); v = int'(ifb.valid); b = int'(ifb.busy); dn = int'(ifb.done); end
      default: begin idx = int'(ifc.idx_out); v = int'(ifc.valid); b = int'(ifc.busy); dn = int'(ifc.done); end
    endcase
    if (exp_idx >= 0) chk({name, ".idx"}, idx, exp_idx);
    chk({name, ".valid"}, v, ev);
    chk({name, ".busy"}, b, eb);
    chk({name, ".done"}, dn, ed);
  endtask

  task automatic add(input int d, input logic [7:0] r, input int n,
                     input int a0, input int a1, input int a2, input int a3,
                     input string name);
    vec_t v;
    v.dut = d; v.req = r; v.n = n; v.name = name;
    v.seq[0] = a0; v.seq[1] = a1; v.seq[2] = a2; v.seq[3] = a3;
    tbl.push_back(v);
  endtask

  task automatic run_burst(input vec_t v);
    @(negedge clk);
    drive(v.dut, 1'b1, v.req);
    set_rdy(1'b1);
    @(negedge clk);
    drive(v.dut, 1'b0, 8'h00);
    for (int k = 0; k < v.n; k++) begin
      expect_out(v.dut, $sformatf("%s[%0d]", v.name, k), v.seq[k], 1, 1, 0);
      @(negedge clk);
    end
    expect_out(v.dut, {v.name, ".end"}, (v.n > 0) ? v.seq[v.n - 1] : -1, 0, 0, 1);
    @(negedge clk);
    expect_out(v.dut, {v.name, ".after"}, -1, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    set_rdy(1'b0);
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);

    // Table: MODE1 entries are ordered; each one leaves the pointer
    // where the next expects it (7 -> 1 -> 2 -> 0).
    add(0, 8'b1010_0110, 4, 7, 5, 2, 1, "m0_a6");
    add(0, 8'h00,        0, 0, 0, 0, 0, "m0_empty");
    add(1, 8'b0000_0100, 1, 2, 0, 0, 0, "m1_burstA");
    add(1, 8'b1000_1001, 3, 0, 7, 3, 0, "m1_burstB");
    add(0, 8'b1000_1001, 3, 7, 3, 0, 0, "m0_burstB");
    add(1, 8'b0000_0010, 1, 1, 0, 0, 0, "m1_ptr_to0");
    for (int r = 1; r < 16; r++) begin
      int cnt;
      int s[4];
      logic [3:0] rb;
      rb = 4'(r);
      cnt = 0;
      s = '{0, 0, 0, 0};
      for (int b = 3; b >= 0; b--) begin
        if (rb[b]) begin
          s[cnt] = b;
          cnt++;
        end
      end
      add(2, {4'h0, rb}, cnt, s[0], s[1], s[2], s[3], $sformatf("n4_%0d", r));
    end

    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_out(0, "rst_m0", 0, 0, 0, 0);
    expect_out(1, "rst_m1", 0, 0, 0, 0);
    expect_out(2, "rst_n4", 0, 0, 0, 0);

    foreach (tbl[i]) run_burst(tbl[i]);

    // Backpressure: index 7 held for several stalled cycles.
    @(negedge clk);
    drive(0, 1'b1, 8'b1010_0110);
    set_rdy(1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    for (int h = 0; h < 3; h++) begin
      expect_out(0, $sformatf("bp_hold%0d", h), 7, 1, 1, 0);
      @(negedge clk);
    end
    expect_out(0, "bp_hold3", 7, 1, 1, 0);
    set_rdy(1'b1);
    @(negedge clk); expect_out(0, "bp_5", 5, 1, 1, 0);
    @(negedge clk); expect_out(0, "bp_2", 2, 1, 1, 0);
    @(negedge clk); expect_out(0, "bp_1", 1, 1, 1, 0);
    @(negedge clk); expect_out(0, "bp_done", 1, 0, 0, 1);
    @(negedge clk); expect_out(0, "bp_after", -1, 0, 0, 0);

    // Load while busy is ignored; load in the done cycle is accepted.
    drive(0, 1'b1, 8'b1010_0110);
    @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    expect_out(0, "lb_7", 7, 1, 1, 0);
    @(negedge clk); expect_out(0, "lb_5", 5, 1, 1, 0);
    @(negedge clk); expect_out(0, "lb_2", 2, 1, 1, 0);
    @(negedge clk); expect_out(0, "lb_1", 1, 1, 1, 0);
    drive(0, 1'b0, 8'h00);
    @(negedge clk); expect_out(0, "lb_done", 1, 0, 0, 1);
    drive(0, 1'b1, 8'h01);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    expect_out(0, "b2b_0", 0, 1, 1, 0);
    @(negedge clk); expect_out(0, "b2b_done", 0, 0, 0, 1);
    @(negedge clk); expect_out(0, "b2b_after", -1, 0, 0, 0);

    // Reset mid-burst after 7 is consumed; MODE1 pointer (currently 0)
    // must restart at 7, giving 1,0 rather than 0,1.
    drive(0, 1'b1, 8'b1010_0110);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    expect_out(0, "mr_7", 7, 1, 1, 0);
    @(negedge clk);
    expect_out(0, "mr_5", 5, 1, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_out(0, "mr_rst", 0, 0, 0, 0);
    @(negedge clk);
    expect_out(0, "mr_nodone", 0, 0, 0, 0);
    v.dut = 1; v.req = 8'b0000_0011; v.n = 2; v.name = "mr_m1_03";
    v.seq[0] = 1; v.seq[1] = 0; v.seq[2] = 0; v.seq[3] = 0;
    run_burst(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
